load_store_unit: RTL and testbench

Sequential RV32I load/store unit between the execute stage and the data-memory bus. It accepts one load or store per request handshake, then drives a word-aligned valid/ready memory bus with byte write masks. When `MISALIGNED_EN` is set, it splits misaligned halfword and word accesses into two bus beats. Load data is merged, aligned, and sign- or zero-extended before it is returned on a single-cycle response.

---
 rtl/load_store_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: sequential RV32I load/store unit sitting between execute and the data bus.
// Accepts one load or store per request handshake, issues one or two word-aligned bus beats
// (two when a misaligned access straddles a word and MISALIGNED_EN is set), then returns a
// single-cycle response carrying the aligned and extended load data.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_we, req_funct3         store select and RV32I access width/sign
//   req_addr, req_wdata        byte address and store data
//   req_rd                     destination tag, echoed on rsp_rd
//   rsp_valid                  one-cycle completion pulse, no backpressure
//   rsp_data, rsp_rd           extended load result (0 for stores/faults), echoed tag
//   rsp_fault                  illegal funct3 or disallowed misaligned access
//   mem_valid / mem_ready      bus beat handshake
//   mem_addr, mem_we           word-aligned beat address, write beat
//   mem_wmask, mem_wdata       byte-lane enables (0 on reads), lane-positioned store data
//   mem_rvalid, mem_rdata      read data return for the outstanding read beat
module load_store_unit #(
    parameter int unsigned ADDR_W        = 32,
    parameter bit          MISALIGNED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StReq0  = 3'd1;
    localparam logic [2:0] StWait0 = 3'd2;
    localparam logic [2:0] StReq1  = 3'd3;
    localparam logic [2:0] StWait1 = 3'd4;
    localparam logic [2:0] StResp  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [4:0]        rd_q;
    logic              fault_q;
    logic [31:0]       lo_q;
    logic [31:0]       hi_q;

    // ------------------------------------------------------------------
    // Request classification (only feeds next-state and latched fault)
    // ------------------------------------------------------------------
    logic req_illegal;
    logic req_misaligned;
    logic req_bad;

    always_comb begin
        if (req_we) begin
            req_illegal = (req_funct3 > 3'b010);
        end else begin
            // Loads: 011, 110, 111 are undefined.
            req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11);
        end
        unique case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
        req_bad = req_illegal || (req_misaligned && !MISALIGNED_EN);
    end

    // ------------------------------------------------------------------
    // Beat geometry derived from the latched request
    // ------------------------------------------------------------------
    logic [1:0]        off;
    logic [3:0]        size_lanes;
    logic [7:0]        lanes8;
    logic [3:0]        mask0;
    logic [3:0]        mask1;
    logic              split;
    logic [ADDR_W-1:0] word0;
    logic [ADDR_W-1:0] word1;
    logic [63:0]       wdata_dup;
    logic [31:0]       wdata_rot;

    always_comb begin
        off = addr_q[1:0];
        unique case (funct3_q[1:0])
            2'b00:   size_lanes = 4'b0001;
            2'b01:   size_lanes = 4'b0011;
            default: size_lanes = 4'b1111;
        endcase
        // Lanes that spill past byte 3 land in the upper nibble and belong to the next word.
        lanes8    = {4'b0000, size_lanes} << off;
        mask0     = lanes8[3:0];
        mask1     = lanes8[7:4];
        split     = |mask1;
        word0     = {addr_q[ADDR_W-1:2], 2'b00};
        word1     = word0 + ADDR_W'(4);
        // Rotate-left by 8*off: upper half of the duplicated word after the shift.
        wdata_dup = {wdata_q, wdata_q} << {off, 3'b000};
        wdata_rot = wdata_dup[63:32];
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = req_bad ? StResp : StReq0;
                end
            end
            StReq0: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        state_d = StWait0;
                    end else begin
                        state_d = split ? StReq1 : StResp;
                    end
                end
            end
            StWait0: begin
                if (mem_rvalid) begin
                    state_d = split ? StReq1 : StResp;
                end
            end
            StReq1: begin
                if (mem_ready) begin
                    state_d = we_q ? StResp : StWait1;
                end
            end
            StWait1: begin
                if (mem_rvalid) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // State and latched fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            fault_q  <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rd_q     <= req_rd;
                fault_q  <= req_bad;
                // hi must read as zero for unsplit loads.
                lo_q     <= '0;
                hi_q     <= '0;
            end
            if (state_q == StWait0 && mem_rvalid) begin
                lo_q <= mem_rdata;
            end
            if (state_q == StWait1 && mem_rvalid) begin
                hi_q <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load result alignment and extension
    // ------------------------------------------------------------------
    logic [63:0] load_shift;
    logic [31:0] load_word;
    logic [31:0] load_ext;

    always_comb begin
        load_shift = {hi_q, lo_q} >> {off, 3'b000};
        load_word  = load_shift[31:0];
        unique case (funct3_q)
            3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b100:  load_ext = {24'h000000, load_word[7:0]};
            3'b101:  load_ext = {16'h0000, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    logic in_req0;
    logic in_req1;
    logic in_resp;

    always_comb begin
        in_req0   = (state_q == StReq0);
        in_req1   = (state_q == StReq1);
        in_resp   = (state_q == StResp);

        req_ready = (state_q == StIdle);

        mem_valid = in_req0 || in_req1;
        mem_we    = mem_valid && we_q;
        mem_addr  = '0;
        mem_wmask = 4'b0000;
        mem_wdata = '0;
        if (in_req0) begin
            mem_addr = word0;
        end else if (in_req1) begin
            mem_addr = word1;
        end
        if (mem_we) begin
            mem_wmask = in_req1 ? mask1 : mask0;
            mem_wdata = wdata_rot;
        end

        rsp_valid = in_resp;
        rsp_rd    = in_resp ? rd_q : 5'd0;
        rsp_fault = in_resp && fault_q;
        rsp_data  = (in_resp && !we_q && !fault_q) ? load_ext : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Main DUT (misaligned splitting enabled)
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    load_store_unit #(.ADDR_W(32), .MISALIGNED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_fault(rsp_fault),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    // Second DUT with misaligned accesses faulting; bus always ready, never returns data
    logic        n_req_valid, n_req_ready, n_req_we;
    logic [2:0]  n_req_funct3;
    logic [31:0] n_req_addr, n_req_wdata;
    logic [4:0]  n_req_rd;
    logic        n_rsp_valid, n_rsp_fault;
    logic [31:0] n_rsp_data;
    logic [4:0]  n_rsp_rd;
    logic        n_mem_valid, n_mem_we;
    logic [31:0] n_mem_addr, n_mem_wdata;
    logic [3:0]  n_mem_wmask;
    logic        n_mem_ready  = 1'b1;
    logic        n_mem_rvalid = 1'b0;
    logic [31:0] n_mem_rdata  = 32'h0;

    load_store_unit #(.ADDR_W(32), .MISALIGNED_EN(1'b0)) dut_nomis (
        .clk(clk), .rst_n(rst_n),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
        .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
        .req_rd(n_req_rd),
        .rsp_valid(n_rsp_valid), .rsp_data(n_rsp_data), .rsp_rd(n_rsp_rd),
        .rsp_fault(n_rsp_fault),
        .mem_valid(n_mem_valid), .mem_ready(n_mem_ready), .mem_addr(n_mem_addr),
        .mem_we(n_mem_we), .mem_wmask(n_mem_wmask), .mem_wdata(n_mem_wdata),
        .mem_rvalid(n_mem_rvalid), .mem_rdata(n_mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sparse word memory; unwritten words read back a fixed address-derived pattern.
    bit [31:0] mem [bit [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] waddr);
        if (mem.exists(waddr)) return mem[waddr];
        return waddr * 32'h9E3779B1;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_rd({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    // Reference: byte-level view of the access, grouped into words.
    task automatic model(input logic mis_en, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic fault, output int nbeats,
                         output logic [1:0][31:0] baddr, output logic [1:0][3:0] bmask,
                         output logic [31:0] bwdata, output logic [31:0] rdata);
        int size;
        logic legal;
        logic [31:0] ba, val;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        fault = !legal || (!mis_en && (addr % size) != 0);
        nbeats = 0;
        baddr  = '0;
        bmask  = '0;
        bwdata = '0;
        rdata  = '0;
        if (!fault) begin
            baddr[0] = addr & ~32'h3;
            baddr[1] = baddr[0];
            val = '0;
            for (int i = 0; i < size; i++) begin
                ba = addr + i;
                if ((ba & ~32'h3) == baddr[0]) bmask[0][ba[1:0]] = 1'b1;
                else begin
                    bmask[1][ba[1:0]] = 1'b1;
                    baddr[1] = ba & ~32'h3;
                end
                val[8*i +: 8] = mem_byte(ba);
            end
            nbeats = (bmask[1] != 4'b0) ? 2 : 1;
            for (int l = 0; l < 4; l++) bwdata[8*l +: 8] = wd[8*((l - addr[1:0]) & 3) +: 8];
            if (!we) begin
                if (f3 == 3'd0)      rdata = {{24{val[7]}}, val[7:0]};
                else if (f3 == 3'd1) rdata = {{16{val[15]}}, val[15:0]};
                else                 rdata = val;
            end
        end
    endtask

    logic [31:0] last_data;

    // One complete transaction on the main DUT with a reactive bus model.
    task automatic run_op(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input int rdly, input int rvdly);
        logic efault;
        int enb, exp_lat, rsp_cyc, nbeat, bwait, rvcnt;
        logic [1:0][31:0] eaddr, gaddr, gwd;
        logic [1:0][3:0] emask, gmask;
        logic [1:0] gwe;
        logic [31:0] ewd, edata, rvaddr, held_addr, held_wd, w;
        logic [3:0] held_mask;
        logic got_fault, stable_ok, busy_ok, done;
        logic [4:0] got_rd;

        model(1'b1, we, f3, addr, wd, efault, enb, eaddr, emask, ewd, edata);
        exp_lat = efault ? 1 : 1 + enb * (1 + rdly + (we ? 0 : rvdly));

        @(negedge clk);
        check_eq({nm, ":idle"}, req_ready, 1);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
        @(negedge clk);
        req_valid = 0;
        req_addr  = $urandom; req_wdata = $urandom; req_we = $urandom_range(0, 1);

        rsp_cyc = 0; nbeat = 0; bwait = 0; rvcnt = 0; rvaddr = 0;
        stable_ok = 1; busy_ok = 1; done = 0;
        gaddr = '0; gmask = '0; gwe = '0; gwd = '0;
        held_addr = 0; held_mask = 0; held_wd = 0;
        got_fault = 0; got_rd = 0; last_data = 0;
        for (int c = 1; c <= 300 && !done; c++) begin
            if (c > 1) @(negedge clk);
            if (rsp_valid) begin
                done = 1; rsp_cyc = c;
                last_data = rsp_data; got_fault = rsp_fault; got_rd = rsp_rd;
                mem_ready = 0; mem_rvalid = 0;
            end else begin
                if (req_ready) busy_ok = 0;
                mem_rvalid = 0;
                if (rvcnt > 0) begin
                    rvcnt--;
                    if (rvcnt == 0) begin
                        mem_rvalid = 1;
                        mem_rdata  = mem_rd(rvaddr);
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    // Stray read data while nothing is outstanding must be ignored.
                    mem_rvalid = 1;
                    mem_rdata  = $urandom;
                end
                if (mem_valid) begin
                    if (bwait == 0) begin
                        held_addr = mem_addr; held_mask = mem_wmask; held_wd = mem_wdata;
                    end else if (mem_addr !== held_addr || mem_wmask !== held_mask ||
                                 mem_wdata !== held_wd) begin
                        stable_ok = 0;
                    end
                    mem_ready = (bwait >= rdly);
                    if (mem_ready) begin
                        if (nbeat < 2) begin
                            gaddr[nbeat] = mem_addr; gmask[nbeat] = mem_wmask;
                            gwe[nbeat] = mem_we; gwd[nbeat] = mem_wdata;
                        end
                        nbeat++;
                        if (mem_we) begin
                            w = mem_rd(mem_addr);
                            for (int l = 0; l < 4; l++)
                                if (mem_wmask[l]) w[8*l +: 8] = mem_wdata[8*l +: 8];
                            mem[mem_addr] = w;
                        end else begin
                            rvcnt = rvdly; rvaddr = mem_addr;
                        end
                        bwait = 0;
                    end else begin
                        bwait++;
                    end
                end else begin
                    mem_ready = $urandom_range(0, 1);
                end
            end
        end

        if (!done) begin
            check_eq({nm, ":timeout"}, 0, 1);
        end else begin
            check_eq({nm, ":latency"}, rsp_cyc, exp_lat);
            check_eq({nm, ":data"}, last_data, edata);
            check_eq({nm, ":fault"}, got_fault, efault);
            check_eq({nm, ":rd"}, got_rd, rd);
            check_eq({nm, ":nbeats"}, nbeat, enb);
            for (int b = 0; b < 2; b++) begin
                if (b < enb && b < nbeat) begin
                    check_eq($sformatf("%s:b%0d_addr", nm, b), gaddr[b], eaddr[b]);
                    check_eq($sformatf("%s:b%0d_mask", nm, b), gmask[b], we ? emask[b] : 4'b0);
                    check_eq($sformatf("%s:b%0d_we", nm, b), gwe[b], we);
                    if (we) check_eq($sformatf("%s:b%0d_wdata", nm, b), gwd[b], ewd);
                end
            end
            check_eq({nm, ":stable"}, stable_ok, 1);
            check_eq({nm, ":busy"}, busy_ok, 1);
            @(negedge clk);
            mem_rvalid = 0;
            check_eq({nm, ":one_pulse"}, {rsp_valid, req_ready}, 2'b01);
        end
    endtask

    // Transaction on the faulting-misaligned DUT; only faults and stores are issued here.
    task automatic run_nomis(input string nm, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd, input logic efault,
                             input logic [31:0] eaddr, input logic [3:0] emask,
                             input logic [31:0] ewd);
        int rsp_cyc;
        logic seen_valid, done;
        logic [31:0] gaddr, gwd;
        logic [3:0] gmask;
        logic gwe;
        @(negedge clk);
        n_req_valid = 1; n_req_we = we; n_req_funct3 = f3; n_req_addr = addr;
        n_req_wdata = wd; n_req_rd = 5'd17;
        @(negedge clk);
        n_req_valid = 0;
        seen_valid = 0; done = 0; rsp_cyc = 0;
        gaddr = 0; gmask = 0; gwd = 0; gwe = 0;
        for (int c = 1; c <= 10 && !done; c++) begin
            if (c > 1) @(negedge clk);
            if (n_mem_valid) begin
                seen_valid = 1;
                gaddr = n_mem_addr; gmask = n_mem_wmask; gwd = n_mem_wdata; gwe = n_mem_we;
            end
            if (n_rsp_valid) begin
                done = 1; rsp_cyc = c;
                check_eq({nm, ":fault"}, n_rsp_fault, efault);
                check_eq({nm, ":data"}, n_rsp_data, 0);
                check_eq({nm, ":rd"}, n_rsp_rd, 5'd17);
            end
        end
        check_eq({nm, ":latency"}, rsp_cyc, efault ? 1 : 2);
        check_eq({nm, ":bus_used"}, seen_valid, !efault);
        if (!efault) check_eq({nm, ":beat"}, {gwe, gmask, gaddr, gwd}, {1'b1, emask, eaddr, ewd});
    endtask

    task automatic check_reset_outputs(input string nm);
        check_eq({nm, ":rst_ctl"}, {req_ready, rsp_valid, rsp_fault, rsp_rd, mem_valid, mem_we,
                                    mem_wmask}, {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0});
        check_eq({nm, ":rst_addr_wd"}, {mem_addr, mem_wdata}, 64'h0);
        check_eq({nm, ":rst_data"}, rsp_data, 0);
    endtask

    initial begin
        logic quiet;
        rst_n = 0;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        n_req_valid = 0; n_req_we = 0; n_req_funct3 = 0; n_req_addr = 0; n_req_wdata = 0;
        n_req_rd = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1;

        // Aligned LW then SW
        mem[32'h100] = 32'hDEADBEEF;
        run_op("lw_aligned", 0, 3'b010, 32'h100, 32'h0, 5'd1, 0, 1);
        check_eq("lw_aligned:const", last_data, 32'hDEADBEEF);
        run_op("sw_aligned", 1, 3'b010, 32'h104, 32'h12345678, 5'd2, 0, 1);
        check_eq("sw_aligned:mem", mem_rd(32'h104), 32'h12345678);

        // Byte/half extension
        mem[32'h300] = 32'h80FF7F01;
        run_op("lb_off3", 0, 3'b000, 32'h303, 0, 5'd3, 0, 1);
        check_eq("lb_off3:const", last_data, 32'hFFFFFF80);
        run_op("lbu_off3", 0, 3'b100, 32'h303, 0, 5'd4, 0, 1);
        check_eq("lbu_off3:const", last_data, 32'h00000080);
        run_op("lh_off2", 0, 3'b001, 32'h302, 0, 5'd5, 0, 1);
        check_eq("lh_off2:const", last_data, 32'hFFFF80FF);
        run_op("lhu_off0", 0, 3'b101, 32'h300, 0, 5'd6, 0, 1);
        check_eq("lhu_off0:const", last_data, 32'h00007F01);
        run_op("sb_off2", 1, 3'b000, 32'h302, 32'h000000AB, 5'd7, 0, 1);
        check_eq("sb_off2:mem", mem_rd(32'h300), 32'h80AB7F01);

        // Split accesses
        mem[32'h1FC] = 32'hBBAA0000;
        mem[32'h200] = 32'h0000DDCC;
        run_op("lw_split", 0, 3'b010, 32'h1FE, 0, 5'd8, 0, 1);
        check_eq("lw_split:const", last_data, 32'hDDCCBBAA);
        run_op("sw_split", 1, 3'b010, 32'h203, 32'h44332211, 5'd9, 0, 1);
        check_eq("sw_split:mem", {mem_rd(32'h200), mem_rd(32'h204)},
                 {32'h1100DDCC, mem_rd(32'h204) & 32'hFF000000 | 32'h00443322});

        // Faults
        run_op("ld_f3_011", 0, 3'b011, 32'h100, 0, 5'd10, 0, 1);
        run_op("st_f3_100", 1, 3'b100, 32'h100, 32'h5555AAAA, 5'd11, 0, 1);
        run_nomis("nomis_lw101", 0, 3'b010, 32'h101, 0, 1, 0, 0, 0);
        run_nomis("nomis_lh103", 0, 3'b001, 32'h103, 0, 1, 0, 0, 0);
        run_nomis("nomis_sw102", 1, 3'b010, 32'h102, 32'h1, 1, 0, 0, 0);
        run_nomis("nomis_sb103", 1, 3'b000, 32'h103, 32'h5A, 0, 32'h100, 4'b1000, 32'h5A000000);
        run_nomis("nomis_sh102", 1, 3'b001, 32'h102, 32'hBEEF, 0, 32'h100, 4'b1100,
                  32'hBEEF0000);

        // Backpressure
        run_op("bp_lw", 0, 3'b010, 32'h100, 0, 5'd12, 5, 4);
        run_op("bp_sh_split", 1, 3'b001, 32'h1FF, 32'hCAFE, 5'd13, 5, 1);
        run_op("bp_lh_split", 0, 3'b001, 32'h1FF, 0, 5'd14, 5, 4);

        // Address wrap
        run_op("sw_wrap", 1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, 5'd15, 0, 1);
        run_op("lw_wrap", 0, 3'b010, 32'hFFFFFFFF, 0, 5'd16, 1, 2);

        // Reset while a store beat is being held off
        @(negedge clk);
        req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h203;
        req_wdata = 32'h44332211; req_rd = 5'd21;
        @(negedge clk);
        req_valid = 0; mem_ready = 0;
        check_eq("rst_req0:pre", mem_valid, 1);
        #1 rst_n = 0;
        #1 check_reset_outputs("rst_req0");
        @(negedge clk);
        rst_n = 1;

        // Reset in WAIT0, then a late read return
        @(negedge clk);
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h104; req_rd = 5'd22;
        @(negedge clk);
        req_valid = 0; mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        check_eq("rst_wait0:pre", {mem_valid, req_ready}, 2'b00);
        #1 rst_n = 0;
        #1 check_reset_outputs("rst_wait0");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        mem_rvalid = 0;
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) quiet = 0;
        end
        check_eq("rst_wait0:stray_rvalid", quiet, 1);

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + $urandom_range(0, 7))
                                            : (32'h1F0 + $urandom_range(0, 31));
            run_op($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                   $urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
